stopwatch_ctrl: RTL



---
 rtl/stopwatch_ctrl_if.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and control outputs of the stopwatch control stage (lap signals under STOPWATCH_CTRL_LAP_EN)
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_clr;
  logic       start_resume;
  logic       stop;
  logic       clr;
  logic       tick;
  logic       running;
  logic [1:0] state;
`ifdef STOPWATCH_CTRL_LAP_EN
  logic       btn_lap;
  logic       lap_hold;
`endif
  modport master (
    input  btn_ss, btn_clr,
`ifdef STOPWATCH_CTRL_LAP_EN
    input  btn_lap,
    output lap_hold,
`endif
    output start_resume, stop, clr, tick, running, state
  );
  modport slave (
    output btn_ss, btn_clr,
`ifdef STOPWATCH_CTRL_LAP_EN
    output btn_lap,
    input  lap_hold,
`endif
    input  start_resume, stop, clr, tick, running, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/stop/clear buttons, run/pause/idle FSM and tick divider (lap hold under STOPWATCH_CTRL_LAP_EN)
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TICK_DIV        = 100000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.master bus
);
`ifdef STOPWATCH_CTRL_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] raw;
  assign raw = {bus.btn_lap, bus.btn_clr, bus.btn_ss};
`else
  localparam int NB = 2;
  logic [NB-1:0] raw;
  assign raw = {bus.btn_clr, bus.btn_ss};
`endif
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  logic [NB-1:0] s1_q, s2_q, deb_q, deb_d, debp_q, press;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [TW-1:0] tcnt_q, tcnt_d;
  state_t        state_q, state_d;
  logic          sr_q, sr_d, stop_q, stop_d, clr_q, clr_d;
  logic          ss_p, clr_p;
`ifdef STOPWATCH_CTRL_LAP_EN
  logic          lap_p, lap_q, lap_d;
  assign lap_p = press[2];
  assign bus.lap_hold = lap_q;
`endif
  assign press = deb_q & ~debp_q;
  assign ss_p  = press[0];
  assign clr_p = press[1];
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = (s2_q[i] == deb_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYCLES)) ? '0 : cnt_q[i] + 1'b1;
      deb_d[i] = (s2_q[i] != deb_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES)) ? s2_q[i] : deb_q[i];
    end
  end
  // ss press always wins; clr is only honoured when ss is quiet
  always_comb begin
    state_d = state_q;
    sr_d    = 1'b0;
    stop_d  = 1'b0;
    clr_d   = 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
    lap_d   = lap_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = ss_p ? RUN : IDLE;
        sr_d    = ss_p;
        clr_d   = !ss_p && clr_p;
      end
      RUN: begin
        state_d = ss_p ? PAUSE : RUN;
        stop_d  = ss_p;
`ifdef STOPWATCH_CTRL_LAP_EN
        lap_d   = (!ss_p && !clr_p && lap_p) ? !lap_q : lap_q;
`endif
      end
      PAUSE: begin
        state_d = ss_p ? RUN : (clr_p ? IDLE : PAUSE);
        sr_d    = ss_p;
        clr_d   = !ss_p && clr_p;
      end
      default: state_d = IDLE;
    endcase
`ifdef STOPWATCH_CTRL_LAP_EN
    lap_d = clr_d ? 1'b0 : lap_d;
`endif
  end
  // restarting on start_resume keeps the first tick a full period after the pulse
  always_comb tcnt_d = (state_q != RUN || sr_q || tcnt_q == TW'(TICK_DIV - 1)) ? '0 : tcnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      debp_q  <= '0;
      cnt_q   <= '{default: '0};
      tcnt_q  <= '0;
      state_q <= IDLE;
      sr_q    <= 1'b0;
      stop_q  <= 1'b0;
      clr_q   <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
      lap_q   <= 1'b0;
`endif
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      debp_q  <= deb_q;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      sr_q    <= sr_d;
      stop_q  <= stop_d;
      clr_q   <= clr_d;
`ifdef STOPWATCH_CTRL_LAP_EN
      lap_q   <= lap_d;
`endif
    end
  end
  assign bus.start_resume = sr_q;
  assign bus.stop         = stop_q;
  assign bus.clr          = clr_q;
  assign bus.tick         = state_q == RUN && tcnt_q == TW'(TICK_DIV - 1);
  assign bus.running      = state_q == RUN;
  assign bus.state        = state_q;
endmodule
